// File: rtl/acc_sequencer.sv
// Job sequencer for a systolic accumulator: clears, collects partial-sum beats,
// waits for the adder chain to settle, then stores one word per output index.
module acc_sequencer #(
  parameter int unsigned ARR_SIZE     = 4,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned BEAT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [BEAT_W-1:0] num_beats,
  input  logic [4:0]        num_outputs,
  input  logic [3:0]        base_addr,
  input  logic              beat_valid,
  output logic              beat_ready,
  output logic              acc_reset,
  output logic              store_output,
  output logic [3:0]        op_buffer_address,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DRAIN_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned DRAIN_LAST  = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int unsigned MAX_OUTPUTS = 16;

  // The adder chain must have at least one column to produce anything.
  if (ARR_SIZE == 0) begin : g_bad_arr_size
    $error("acc_sequencer: ARR_SIZE must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_STORE,
    S_DONE,
    S_ABORT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   beat_cnt_nxt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [DRAIN_W-1:0]  drain_cnt_nxt;
  logic [3:0]          index;
  logic [3:0]          index_nxt;
  logic [BEAT_W-1:0]   beats_lat;
  logic [4:0]          outputs_lat;
  logic [3:0]          base_lat;
  logic                job_ok;
  logic                beat_take;
  logic                last_beat;
  logic                drain_last;
  logic                last_output;
  logic                err_nxt;
  logic [3:0]          addr_nxt;

  assign job_ok      = (num_beats != '0) && (num_outputs != 5'd0) &&
                       (num_outputs <= 5'(MAX_OUTPUTS));
  assign beat_take   = (state == S_ACCUM) && beat_valid;
  assign last_beat   = ({1'b0, beat_cnt} + (BEAT_W+1)'(1)) == {1'b0, beats_lat};
  assign drain_last  = drain_cnt == DRAIN_W'(DRAIN_LAST);
  assign last_output = (5'(index) + 5'd1) == outputs_lat;

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    drain_cnt_nxt = drain_cnt;
    index_nxt     = index;
    err_nxt       = 1'b0;
    addr_nxt      = 4'd0;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (job_ok) begin
            state_nxt = S_CLEAR;
            index_nxt = 4'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        beat_cnt_nxt = '0;
        state_nxt    = S_ACCUM;
      end
      S_ACCUM: begin
        if (beat_take) begin
          beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          if (last_beat) begin
            drain_cnt_nxt = '0;
            if (DRAIN_CYCLES == 0) state_nxt = S_STORE;
            else                   state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_last) state_nxt = S_STORE;
        else            drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
      end
      S_STORE: begin
        if (last_output) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_CLEAR;
          index_nxt = index + 4'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides any in-flight transition; ABORT itself always returns to IDLE.
    if (abort && (state != S_IDLE) && (state != S_ABORT)) begin
      state_nxt = S_ABORT;
    end

    if (state_nxt == S_STORE) begin
      addr_nxt = base_lat + index;
    end
  end

  // State, counters, latched job fields and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      beat_cnt          <= '0;
      drain_cnt         <= '0;
      index             <= 4'd0;
      beats_lat         <= '0;
      outputs_lat       <= 5'd0;
      base_lat          <= 4'd0;
      beat_ready        <= 1'b0;
      acc_reset         <= 1'b0;
      store_output      <= 1'b0;
      op_buffer_address <= 4'd0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      index     <= index_nxt;
      if ((state == S_IDLE) && (state_nxt == S_CLEAR)) begin
        beats_lat   <= num_beats;
        outputs_lat <= num_outputs;
        base_lat    <= base_addr;
      end
      beat_ready        <= state_nxt == S_ACCUM;
      acc_reset         <= (state_nxt == S_CLEAR) || (state_nxt == S_ABORT);
      store_output      <= state_nxt == S_STORE;
      op_buffer_address <= addr_nxt;
      busy              <= state_nxt != S_IDLE;
      done              <= state_nxt == S_DONE;
      err               <= err_nxt;
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: directed jobs push expected pulses with
// their cycle numbers; a negedge monitor pops and compares each observed pulse.
module tb_acc_sequencer;

  localparam int K_ACC   = 0;
  localparam int K_STORE = 1;
  localparam int K_DONE  = 2;
  localparam int K_ERR   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] num_beats = 8'd0;
  logic [4:0] num_outputs = 5'd0;
  logic [3:0] base_addr = 4'd0;
  logic       beat_valid = 1'b0;
  logic       beat_ready;
  logic       acc_reset;
  logic       store_output;
  logic [3:0] op_buffer_address;
  logic       busy;
  logic       done;
  logic       err;

  acc_sequencer #(.ARR_SIZE(4), .DRAIN_CYCLES(4), .BEAT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .num_beats         (num_beats),
    .num_outputs       (num_outputs),
    .base_addr         (base_addr),
    .beat_valid        (beat_valid),
    .beat_ready        (beat_ready),
    .acc_reset         (acc_reset),
    .store_output      (store_output),
    .op_buffer_address (op_buffer_address),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  beats_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_ACC:   return "acc_reset";
      K_STORE: return "store_output";
      K_DONE:  return "done";
      default: return "err";
    endcase
  endfunction

  task automatic push(input int kind, input int at, input logic [3:0] addr);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [3:0] addr);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d addr %0d, required none",
               kname(kind), cyc, addr);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == K_STORE && e.addr != addr)) begin
        miscompares++;
        $display("FAIL event: got %s cycle %0d addr %0d, required %s cycle %0d addr %0d",
                 kname(kind), cyc, addr, kname(e.kind), e.cyc, e.addr);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (acc_reset)    check_ev(K_ACC, 4'd0);
    if (store_output) check_ev(K_STORE, op_buffer_address);
    if (done)         check_ev(K_DONE, 4'd0);
    if (err)          check_ev(K_ERR, 4'd0);
    if (beat_valid && beat_ready) beats_seen++;
  end

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Issues a start; t0 is the accepting edge, so cycle k of the job is cyc == t0+k-1.
  task automatic start_job(input logic [7:0] nb, input logic [4:0] no,
                           input logic [3:0] ba, output int t0);
    num_beats   = nb;
    num_outputs = no;
    base_addr   = ba;
    start       = 1'b1;
    t0          = cyc + 1;
    tick();
    start       = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_beat_ready"}, int'(beat_ready), 0);
    chk({tag, "_acc_reset"}, int'(acc_reset), 0);
    chk({tag, "_store_output"}, int'(store_output), 0);
    chk({tag, "_addr"}, int'(op_buffer_address), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    int t0;

    rst = 1'b1;
    ticks(2);
    chk_all_zero("reset");
    rst = 1'b0;
    ticks(2);

    // Basic job: 3 beats, 1 output at address 5.
    beats_seen = 0;
    beat_valid = 1'b1;
    start_job(8'd3, 5'd1, 4'd5, t0);
    push(K_ACC, t0, 4'd0);
    push(K_STORE, t0 + 8, 4'd5);
    push(K_DONE, t0 + 9, 4'd0);
    ticks(2);
    chk("basic_busy_mid", int'(busy), 1);
    ticks(8);
    chk("basic_busy_end", int'(busy), 0);
    chk("basic_beats", beats_seen, 3);

    // Three outputs wrapping from 15, with an ignored start mid-job.
    beats_seen = 0;
    start_job(8'd2, 5'd3, 4'd15, t0);
    push(K_ACC, t0, 4'd0);
    push(K_STORE, t0 + 7, 4'd15);
    push(K_ACC, t0 + 8, 4'd0);
    push(K_STORE, t0 + 15, 4'd0);
    push(K_ACC, t0 + 16, 4'd0);
    push(K_STORE, t0 + 23, 4'd1);
    push(K_DONE, t0 + 24, 4'd0);
    ticks(3);
    num_beats   = 8'd1;
    num_outputs = 5'd1;
    base_addr   = 4'd3;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    ticks(22);
    chk("wrap_busy_end", int'(busy), 0);
    chk("wrap_beats", beats_seen, 6);

    // Stalled beats: valid 1,0,0,1,1 across the ACCUM cycles.
    beats_seen = 0;
    beat_valid = 1'b0;
    start_job(8'd3, 5'd1, 4'd9, t0);
    push(K_ACC, t0, 4'd0);
    push(K_STORE, t0 + 10, 4'd9);
    push(K_DONE, t0 + 11, 4'd0);
    tick(); beat_valid = 1'b1;
    tick(); beat_valid = 1'b0;
    tick(); beat_valid = 1'b0;
    tick(); beat_valid = 1'b1;
    tick(); beat_valid = 1'b1;
    chk("stall_ready_last_beat", int'(beat_ready), 1);
    tick(); beat_valid = 1'b0;
    chk("stall_ready_in_drain", int'(beat_ready), 0);
    ticks(6);
    chk("stall_beats", beats_seen, 3);
    chk("stall_busy_end", int'(busy), 0);

    // Rejected starts, and abort beating start in IDLE.
    beat_valid = 1'b1;
    start_job(8'd0, 5'd1, 4'd2, t0);
    push(K_ERR, t0, 4'd0);
    chk("reject_nb0_busy", int'(busy), 0);
    tick();
    start_job(8'd3, 5'd17, 4'd2, t0);
    push(K_ERR, t0, 4'd0);
    chk("reject_no17_busy", int'(busy), 0);
    tick();
    start_job(8'd3, 5'd0, 4'd2, t0);
    push(K_ERR, t0, 4'd0);
    tick();
    abort = 1'b1;
    start_job(8'd3, 5'd1, 4'd2, t0);
    abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    ticks(2);

    // Abort in ACCUM after one beat, then a normal two-output job.
    beats_seen = 0;
    start_job(8'd4, 5'd1, 4'd2, t0);
    push(K_ACC, t0, 4'd0);
    push(K_ACC, t0 + 3, 4'd0);
    tick();
    tick(); beat_valid = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0;
    tick();
    chk("abort_accum_busy", int'(busy), 0);
    chk("abort_accum_beats", beats_seen, 1);
    beat_valid = 1'b1;
    start_job(8'd2, 5'd2, 4'd7, t0);
    push(K_ACC, t0, 4'd0);
    push(K_STORE, t0 + 7, 4'd7);
    push(K_ACC, t0 + 8, 4'd0);
    push(K_STORE, t0 + 15, 4'd8);
    push(K_DONE, t0 + 16, 4'd0);
    ticks(17);
    chk("after_abort_busy", int'(busy), 0);

    // Abort arriving during STORE: the store stands, no done follows.
    start_job(8'd1, 5'd2, 4'd0, t0);
    push(K_ACC, t0, 4'd0);
    push(K_STORE, t0 + 6, 4'd0);
    push(K_ACC, t0 + 7, 4'd0);
    ticks(6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abort_store_busy", int'(busy), 0);

    // Asynchronous reset in DRAIN, between edges, then a clean basic job.
    start_job(8'd3, 5'd1, 4'd5, t0);
    push(K_ACC, t0, 4'd0);
    ticks(5);
    chk("drain_busy_before_rst", int'(busy), 1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();
    start_job(8'd3, 5'd1, 4'd5, t0);
    push(K_ACC, t0, 4'd0);
    push(K_STORE, t0 + 8, 4'd5);
    push(K_DONE, t0 + 9, 4'd0);
    ticks(10);
    chk("post_rst_busy", int'(busy), 0);

    ticks(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
